// File: rtl/ed25519_host_bridge.sv
// Host-side bridge for the ed25519 core: serializes M/xp/yp into twelve 64-bit
// words and gathers the eight result words back into parallel xg/yg.
module ed25519_host_bridge #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [254:0] i_m,
  input  logic [254:0] i_xp,
  input  logic [254:0] i_yp,
  output logic         o_core_in_valid,
  input  logic         i_core_in_ready,
  output logic [63:0]  o_core_in_data,
  input  logic         i_core_out_valid,
  output logic         o_core_out_ready,
  input  logic [63:0]  i_core_out_data,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [254:0] o_xg,
  output logic [254:0] o_yg,
  output logic         o_timeout,
  output logic         o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_RESP} state_t;

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX   = '1;

  state_t         r_state;
  state_t         w_state_next;
  logic [764:0]   r_buf;
  logic [63:0]    r_in_data;
  logic           r_in_valid;
  logic [3:0]     r_cnt;
  logic [CNT_W-1:0] r_tmo;
  logic [254:0]   r_xg;
  logic [254:0]   r_yg;
  logic           r_timeout;

  logic           w_in_hs;
  logic           w_out_hs;
  logic [3:0]     w_next_idx;
  logic [63:0]    w_word_next;
  logic [764:0]   w_buf_shift;
  logic [CNT_W-1:0] w_tmo_inc;
  logic           w_tmo_hit;
  logic           w_req_ready;
  logic           w_out_ready;
  logic           w_rsp_valid;
  logic           w_busy;

  assign w_in_hs  = r_in_valid & i_core_in_ready;
  assign w_out_hs = (r_state == S_RECV) & i_core_out_valid;

  // Each operand's first word carries only 63 payload bits, so the buffer
  // shifts by 63 before a w0 and by 64 before every other word.
  assign w_next_idx  = r_cnt + 4'd1;
  assign w_word_next = (w_next_idx[1:0] == 2'd0) ? {1'b0, r_buf[764:702]} : r_buf[764:701];
  assign w_buf_shift = (w_next_idx[1:0] == 2'd0) ? (r_buf << 63) : (r_buf << 64);

  assign w_tmo_inc = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + 1'b1;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (w_tmo_inc >= TMO_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_out_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (i_req_valid) w_state_next = S_SEND;
      end
      S_SEND: begin
        if (w_in_hs && (r_cnt == 4'd11)) w_state_next = S_RECV;
      end
      S_RECV: begin
        w_out_ready = 1'b1;
        if (w_out_hs) begin
          if (r_cnt == 4'd7) w_state_next = S_RESP;
        end else if (w_tmo_hit) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf      <= '0;
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_xg       <= '0;
      r_yg       <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_buf      <= {i_m[191:0], i_xp, i_yp, 63'd0};
            r_in_data  <= {1'b0, i_m[254:192]};
            r_in_valid <= 1'b1;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_xg       <= '0;
            r_yg       <= '0;
            r_timeout  <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_in_hs) begin
            if (r_cnt == 4'd11) begin
              r_in_valid <= 1'b0;
              r_in_data  <= '0;
              r_cnt      <= '0;
            end else begin
              r_cnt      <= w_next_idx;
              r_in_data  <= w_word_next;
              r_buf      <= w_buf_shift;
            end
          end
        end
        S_RECV: begin
          if (w_out_hs) begin
            r_tmo <= '0;
            r_cnt <= (r_cnt == 4'd7) ? 4'd0 : w_next_idx;
            // Words 0..3 land in xg, 4..7 in yg; bit 63 of each w0 is dropped.
            if (!r_cnt[2]) begin
              case (r_cnt[1:0])
                2'd0:    r_xg[254:192] <= i_core_out_data[62:0];
                2'd1:    r_xg[191:128] <= i_core_out_data;
                2'd2:    r_xg[127:64]  <= i_core_out_data;
                default: r_xg[63:0]    <= i_core_out_data;
              endcase
            end else begin
              case (r_cnt[1:0])
                2'd0:    r_yg[254:192] <= i_core_out_data[62:0];
                2'd1:    r_yg[191:128] <= i_core_out_data;
                2'd2:    r_yg[127:64]  <= i_core_out_data;
                default: r_yg[63:0]    <= i_core_out_data;
              endcase
            end
          end else begin
            r_tmo <= w_tmo_inc;
            if (w_tmo_hit) begin
              r_timeout <= 1'b1;
              r_cnt     <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready      = w_req_ready;
  assign o_core_in_valid  = r_in_valid;
  assign o_core_in_data   = r_in_data;
  assign o_core_out_ready = w_out_ready;
  assign o_rsp_valid      = w_rsp_valid;
  assign o_xg             = r_xg;
  assign o_yg             = r_yg;
  assign o_timeout        = r_timeout;
  assign o_busy           = w_busy;

endmodule

// File: tb/tb_ed25519_host_bridge.sv
// Bench for ed25519_host_bridge: vector table plus scoreboard of core-bound
// words and host responses, with stall, timeout and mid-transfer reset cases.
module tb_ed25519_host_bridge;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_req_valid;
  logic         o_req_ready;
  logic [254:0] i_m, i_xp, i_yp;
  logic         o_core_in_valid;
  logic         i_core_in_ready;
  logic [63:0]  o_core_in_data;
  logic         i_core_out_valid;
  logic         o_core_out_ready;
  logic [63:0]  i_core_out_data;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [254:0] o_xg, o_yg;
  logic         o_timeout;
  logic         o_busy;

  always #5 i_clk = ~i_clk;

  ed25519_host_bridge #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_m(i_m), .i_xp(i_xp), .i_yp(i_yp),
    .o_core_in_valid(o_core_in_valid), .i_core_in_ready(i_core_in_ready),
    .o_core_in_data(o_core_in_data),
    .i_core_out_valid(i_core_out_valid), .o_core_out_ready(o_core_out_ready),
    .i_core_out_data(i_core_out_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_xg(o_xg), .o_yg(o_yg), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  typedef struct {
    logic [254:0]     m, xp, yp;
    logic [7:0][63:0] rw;
    int               nres;
    int               mode;
    logic [254:0]     xg, yg;
    logic             to;
  } vec_t;

  typedef struct {
    logic [254:0] xg, yg;
    logic         to;
  } rsp_t;

  vec_t        vecs[3];
  logic [63:0] exp_in_q[$];
  rsp_t        rsp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;
  logic        prev_v  = 1'b0;
  logic        prev_r  = 1'b0;
  logic [63:0] prev_d  = '0;

  task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] op_word(input logic [254:0] op, input int k);
    case (k)
      0:       return {1'b0, op[254:192]};
      1:       return op[191:128];
      2:       return op[127:64];
      default: return op[63:0];
    endcase
  endfunction

  // Core-side monitor: pops the expected word on every input handshake.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (prev_v && !prev_r)
        chk("stall_hold", {o_core_in_valid, o_core_in_data}, {1'b1, prev_d});
      if (o_core_in_valid)
        chk("flags_in_send", {o_req_ready, o_busy, o_core_out_ready}, 3'b010);
      if (o_core_in_valid && i_core_in_ready) begin
        if (exp_in_q.size() == 0) chk("extra_word", 1'b1, 1'b0);
        else chk("core_word", o_core_in_data, exp_in_q.pop_front());
      end
      prev_v <= o_core_in_valid;
      prev_r <= i_core_in_ready;
      prev_d <= o_core_in_data;
    end else begin
      prev_v <= 1'b0;
    end
  end

  task automatic do_request(input logic [254:0] m, input logic [254:0] xp, input logic [254:0] yp);
    for (int k = 0; k < 4; k++) exp_in_q.push_back(op_word(m, k));
    for (int k = 0; k < 4; k++) exp_in_q.push_back(op_word(xp, k));
    for (int k = 0; k < 4; k++) exp_in_q.push_back(op_word(yp, k));
    chk("req_ready_idle", o_req_ready, 1'b1);
    i_m = m; i_xp = xp; i_yp = yp;
    i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    // Keep a bogus request and bogus result word asserted while sending.
    i_m = ~m; i_xp = ~xp; i_yp = ~yp;
    i_core_out_valid = 1'b1;
    i_core_out_data  = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic run_send(input int mode, input int max_hs, output int cyc);
    int   hs;
    logic w;
    hs = 0; cyc = 0;
    while (hs < max_hs && cyc < 200) begin
      i_core_in_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge i_clk);
      w = o_core_in_valid && i_core_in_ready;
      @(posedge i_clk); #1;
      if (w) hs++;
      cyc++;
    end
    if (hs < max_hs) chk("send_budget", 255'(hs), 255'(max_hs));
  endtask

  task automatic run_recv(input int i);
    logic got;
    int   idle;
    for (int k = 0; k < vecs[i].nres; k++) begin
      i_core_out_valid = 1'b1;
      i_core_out_data  = vecs[i].rw[k];
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge i_clk);
        got = o_core_out_ready;
        @(posedge i_clk); #1;
      end
      if (!got) chk("out_hs_budget", 1'b0, 1'b1);
    end
    i_core_out_valid = 1'b0;
    if (vecs[i].nres == 8) begin
      chk("rsp_latency", o_rsp_valid, 1'b1);
    end else begin
      idle = 0;
      while (!o_rsp_valid && idle < 100) begin
        @(posedge i_clk); #1;
        idle++;
      end
      chk("timeout_cycles", 255'(idle), 255'd16);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (rsp_q.size() == 0) begin
      chk("rsp_q_empty", 1'b1, 1'b0);
      return;
    end
    e = rsp_q.pop_front();
    chk("rsp_valid", o_rsp_valid, 1'b1);
    chk("xg", o_xg, e.xg);
    chk("yg", o_yg, e.yg);
    chk("timeout", o_timeout, e.to);
    i_rsp_ready = 1'b0;
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    chk("rsp_hold", {o_rsp_valid, o_timeout, o_req_ready}, {1'b1, e.to, 1'b0});
    chk("xg_hold", o_xg, e.xg);
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    chk("rsp_release", {o_rsp_valid, o_req_ready, o_busy}, 3'b010);
  endtask

  task automatic run_vector(input int i);
    int   cyc;
    rsp_t r;
    r.xg = vecs[i].xg; r.yg = vecs[i].yg; r.to = vecs[i].to;
    rsp_q.push_back(r);
    do_request(vecs[i].m, vecs[i].xp, vecs[i].yp);
    run_send(vecs[i].mode, 12, cyc);
    i_req_valid      = 1'b0;
    i_core_out_valid = 1'b0;
    if (vecs[i].mode == 0) chk("send_latency", 255'(cyc), 255'd12);
    chk("in_q_drained", 255'(exp_in_q.size()), 255'd0);
    chk("recv_entry", {o_core_in_valid, o_core_out_ready, o_busy}, 3'b011);
    run_recv(i);
    check_rsp();
    $display("[TB] txn vec=%0d mode=%0d words=%0d xg=%h yg=%h to=%0b",
             i, vecs[i].mode, vecs[i].nres, o_xg, o_yg, o_timeout);
  endtask

  initial begin
    int cyc;

    vecs[0].m  = 255'd1; vecs[0].xp = 255'd2; vecs[0].yp = 255'd3;
    vecs[0].rw = '0;
    vecs[0].rw[0] = 64'hFFFF_FFFF_FFFF_FFFF; vecs[0].rw[1] = 64'hA;
    vecs[0].rw[2] = 64'hB; vecs[0].rw[3] = 64'hC; vecs[0].rw[7] = 64'h5;
    vecs[0].nres = 8; vecs[0].mode = 0;
    vecs[0].xg = {63'h7FFF_FFFF_FFFF_FFFF, 64'hA, 64'hB, 64'hC};
    vecs[0].yg = 255'd5; vecs[0].to = 1'b0;

    vecs[1].m  = {255{1'b1}}; vecs[1].xp = {255{1'b1}}; vecs[1].yp = {255{1'b1}};
    for (int k = 0; k < 8; k++) vecs[1].rw[k] = 64'(k + 1);
    vecs[1].nres = 8; vecs[1].mode = 1;
    vecs[1].xg = {63'h1, 64'h2, 64'h3, 64'h4};
    vecs[1].yg = {63'h5, 64'h6, 64'h7, 64'h8};
    vecs[1].to = 1'b0;

    vecs[2].m  = {63'h1234_5678_9ABC_DEF0, 64'h0F1E_2D3C_4B5A_6978,
                  64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    vecs[2].xp = 255'hCAFE;
    vecs[2].yp = {1'b1, 254'd0};
    vecs[2].rw = '0;
    vecs[2].rw[0] = 64'h8000_0000_0000_0001; vecs[2].rw[1] = 64'hDEAD;
    vecs[2].rw[2] = 64'hBEEF;
    vecs[2].nres = 3; vecs[2].mode = 0;
    vecs[2].xg = {63'h1, 64'hDEAD, 64'hBEEF, 64'h0};
    vecs[2].yg = '0; vecs[2].to = 1'b1;

    i_rst_n = 1'b0; i_req_valid = 1'b0; i_m = '0; i_xp = '0; i_yp = '0;
    i_core_in_ready = 1'b1; i_core_out_valid = 1'b0; i_core_out_data = '0;
    i_rsp_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_flags", {o_req_ready, o_core_in_valid, o_core_out_ready, o_rsp_valid, o_timeout, o_busy}, 6'b100000);
    chk("reset_data", {o_core_in_data, o_xg[63:0], o_yg[63:0]}, '0);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 3; i++) run_vector(i);

    // Reset asserted while the sixth word is on the bus.
    do_request(vecs[0].m, vecs[0].xp, vecs[0].yp);
    run_send(0, 5, cyc);
    i_req_valid = 1'b0; i_core_out_valid = 1'b0;
    chk("mid_send_word5", {o_core_in_valid, o_core_in_data}, {1'b1, 64'h0});
    mon_en = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {o_req_ready, o_core_in_valid, o_core_out_ready, o_rsp_valid, o_timeout, o_busy}, 6'b100000);
    chk("async_reset_data", o_core_in_data, '0);
    chk("async_reset_xg", o_xg, '0);
    chk("async_reset_yg", o_yg, '0);
    exp_in_q.delete();
    $display("[TB] txn reset mid-send after 5 words");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    run_vector(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
